adc_spi_writer: RTL and testbench
=================================

Name: adc_spi_writer

Overview:
- SPI configuration master for the two HSMC ADC channels (A and B).
- Serialises single-byte register writes on the shared ad_sclk / ad_sdio lines, using per-channel active-low chip selects.
- Replaces the static tie-offs on the ADC SPI pins. Driven by the Nios control path or a power-up init sequencer through a start/ready handshake.
- Write-only (3-wire SDIO is never turned around). Runs on sys_clk.

Parameters:
- CLK_DIV, 4, sys_clk cycles per ad_sclk half-period (>=1)
- CS_SETUP, 2, cycles from CS falling to the first ad_sclk rising edge's low phase start (>=1)
- CS_HOLD, 2, cycles from the last ad_sclk falling edge to CS rising (>=1)
- CS_IDLE, 4, minimum CS-high cycles between frames (>=1)

Ports:
- clk  in  1  sys_clk domain clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a write; accepted only when ready=1 and adc_sel!=0
- adc_sel  in  2  bit0=ADC A, bit1=ADC B; both set = broadcast write
- addr  in  13  ADC register address
- wdata  in  8  register data
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse at frame completion
- ad_sclk  out  1  SPI clock, idles low
- ad_sdio  out  1  SPI data out, idles high
- ada_spi_cs  out  1  ADC A chip select, active low
- adb_spi_cs  out  1  ADC B chip select, active low

Behaviour:
- All outputs are registered.
- Reset values: ready=1, done=0, ad_sclk=0, ad_sdio=1, ada_spi_cs=1, adb_spi_cs=1.
- Reset mid-frame aborts on the next edge with these values; there is no partial-frame completion.
- Accept: start=1 & ready=1 & adc_sel!=0 at edge k.
  - adc_sel, addr and wdata are latched; ready=0 from k+1.
  - start with adc_sel==0 is ignored; start while ready=0 is ignored.
- Frame: 24 bits, MSB first = {1'b0 (write), 2'b00 (1 byte), addr[12:0], wdata[7:0]}.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP:
  - Selected CS lines go low at k+1; ad_sclk=0; ad_sdio=frame bit23.
  - Lasts CS_SETUP cycles.
- SHIFT: per bit, ad_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the high->low transition ad_sdio advances to the next bit, so data is stable across every rising edge.
  - Bit counter runs 23 down to 0; 24 rising edges exactly.
  - Lasts 48*CLK_DIV cycles.
- HOLD: ad_sclk=0, ad_sdio holds bit0, CS stays low for CS_HOLD cycles.
- GAP:
  - All CS high, ad_sdio=1, for CS_IDLE cycles.
  - On exit, done=1 and ready=1 in the same cycle.
- Unselected CS stays high for the entire frame.
- Timing with default parameters, accept at edge k:
  - CS low for cycles k+1..k+196.
  - CS high at k+197.
  - done=1 and ready=1 at k+201.
- Back-to-back: start held high is accepted in the cycle ready=1, so CS is high for at least CS_IDLE cycles between frames.
- Internal counters are sized from the parameters (clog2) and never wrap within a frame.

Test Plan:
- Single write: adc_sel=01, addr=0x014, wdata=0xA5 -> a bench SPI slave sampling on ad_sclk rising edges captures exactly 24 bits = 0x0014A5. ada_spi_cs low k+1..k+196, adb_spi_cs constantly 1, done pulse at k+201.
- Broadcast: adc_sel=11, addr=0x0FF, wdata=0x01 -> both CS fall and rise on the same cycles; captured word 0x00FF01.
- Ignored requests:
  - start pulsed at k+50 during a frame -> no effect; exactly one done.
  - start with adc_sel=00 while idle -> ready stays 1, no CS activity.
- Reset mid-frame: rst=1 at 10th rising sclk -> next cycle ready=1, CS=11, ad_sclk=0, ad_sdio=1, no done. A following write of 0x0014A5 captures correctly.
- Back-to-back: start held high with two queued writes (0x0014A5, then 0x0FF01) -> second frame's CS falls exactly CS_IDLE+1 cycles after the first frame's CS rises; both words correct.
- Parameter sweep: CLK_DIV=1 and CLK_DIV=7 -> sclk half-period equals CLK_DIV cycles, 24 rising edges; ad_sdio never changes within ±0 cycles of a rising edge.

Source files
------------

// File: rtl/adc_spi_writer.sv
// SPI write-only configuration master for the two HSMC ADC channels.
// Shifts one 24-bit register-write frame on shared sclk/sdio with per-channel chip selects.
module adc_spi_writer #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  adc_sel,
   input  logic [12:0] addr,
   input  logic [7:0]  wdata,
   output logic        ready,
   output logic        done,
   output logic        ad_sclk,
   output logic        ad_sdio,
   output logic        ada_spi_cs,
   output logic        adb_spi_cs
);

   localparam int unsigned FRAME_W = 24;
   localparam int unsigned BIT_W   = $clog2(FRAME_W);
   localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
   localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(FRAME_W - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [BIT_W-1:0]   bit_nxt;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               ready_d, done_d, sclk_d, sdio_d, csa_d, csb_d;
   logic               accept;

   // State and registered outputs; every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         frame_q    <= '0;
         ready      <= 1'b1;
         done       <= 1'b0;
         ad_sclk    <= 1'b0;
         ad_sdio    <= 1'b1;
         ada_spi_cs <= 1'b1;
         adb_spi_cs <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         ready      <= ready_d;
         done       <= done_d;
         ad_sclk    <= sclk_d;
         ad_sdio    <= sdio_d;
         ada_spi_cs <= csa_d;
         adb_spi_cs <= csb_d;
      end
   end

   // Next state; outputs are computed for the first cycle of the phase being entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      ready_d = ready;
      done_d  = 1'b0;
      sclk_d  = ad_sclk;
      sdio_d  = ad_sdio;
      csa_d   = ada_spi_cs;
      csb_d   = adb_spi_cs;
      bit_nxt = bit_q - BIT_W'(1);
      accept  = start & ready & (adc_sel != 2'b00);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               frame_d = {1'b0, 2'b00, addr, wdata};
               state_d = ST_SETUP;
               cnt_d   = '0;
               ready_d = 1'b0;
               csa_d   = ~adc_sel[0];
               csb_d   = ~adc_sel[1];
               sclk_d  = 1'b0;
               sdio_d  = frame_d[FRAME_W-1];
            end
         end

         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
               bit_d   = BIT_FIRST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Data only moves on the falling edge so it is stable around each rising edge.
         ST_SHIFT: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!ad_sclk) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == '0) begin
                     state_d = ST_HOLD;
                  end else begin
                     bit_d  = bit_nxt;
                     sdio_d = frame_q[bit_nxt];
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               csa_d   = 1'b1;
               csb_d   = 1'b1;
               sdio_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_GAP: begin
            if (cnt_q == IDLE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            sclk_d  = 1'b0;
            sdio_d  = 1'b1;
            csa_d   = 1'b1;
            csb_d   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_adc_spi_writer.sv
// Directed bench for adc_spi_writer: default instance plus CLK_DIV=1 and CLK_DIV=7 instances,
// each observed by a small SPI slave that samples sdio on sclk rising edges.
module tb_adc_spi_writer;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst     [N];
   logic        start   [N];
   logic [1:0]  adc_sel [N];
   logic [12:0] addr    [N];
   logic [7:0]  wdata   [N];
   logic        ready_w [N];
   logic        done_w  [N];
   logic        sclk_w  [N];
   logic        sdio_w  [N];
   logic        csa_w   [N];
   logic        csb_w   [N];

   int div_v [N] = '{4, 1, 7};

   adc_spi_writer u_dut (
      .clk(clk), .rst(rst[0]), .start(start[0]), .adc_sel(adc_sel[0]), .addr(addr[0]),
      .wdata(wdata[0]), .ready(ready_w[0]), .done(done_w[0]), .ad_sclk(sclk_w[0]),
      .ad_sdio(sdio_w[0]), .ada_spi_cs(csa_w[0]), .adb_spi_cs(csb_w[0]));

   adc_spi_writer #(.CLK_DIV(1)) u_div1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .adc_sel(adc_sel[1]), .addr(addr[1]),
      .wdata(wdata[1]), .ready(ready_w[1]), .done(done_w[1]), .ad_sclk(sclk_w[1]),
      .ad_sdio(sdio_w[1]), .ada_spi_cs(csa_w[1]), .adb_spi_cs(csb_w[1]));

   adc_spi_writer #(.CLK_DIV(7)) u_div7 (
      .clk(clk), .rst(rst[2]), .start(start[2]), .adc_sel(adc_sel[2]), .addr(addr[2]),
      .wdata(wdata[2]), .ready(ready_w[2]), .done(done_w[2]), .ad_sclk(sclk_w[2]),
      .ad_sdio(sdio_w[2]), .ada_spi_cs(csa_w[2]), .adb_spi_cs(csb_w[2]));

   // SPI slave / timing monitor, sampled on the falling clk edge
   int          cyc = 0;
   logic [23:0] cap       [N] = '{default: 24'h0};
   int          nb        [N] = '{default: 0};
   int          viol      [N] = '{default: 0};
   int          perbad    [N] = '{default: 0};
   int          last_rise [N] = '{default: -1};
   int          fa        [N] = '{default: 0};
   int          ra        [N] = '{default: 0};
   int          fb        [N] = '{default: 0};
   int          rb        [N] = '{default: 0};
   int          dn        [N] = '{default: 0};
   int          dcnt      [N] = '{default: 0};
   int          alow      [N] = '{default: 0};
   int          blow      [N] = '{default: 0};
   logic        sclk_p    [N] = '{default: 1'b0};
   logic        sdio_p    [N] = '{default: 1'b1};
   logic        csa_p     [N] = '{default: 1'b1};
   logic        csb_p     [N] = '{default: 1'b1};

   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (!csa_w[i] && csa_p[i]) fa[i] = cyc;
         if (csa_w[i] && !csa_p[i]) ra[i] = cyc;
         if (!csb_w[i] && csb_p[i]) fb[i] = cyc;
         if (csb_w[i] && !csb_p[i]) rb[i] = cyc;
         if (!csa_w[i]) alow[i] = alow[i] + 1;
         if (!csb_w[i]) blow[i] = blow[i] + 1;
         if (!(csa_w[i] & csb_w[i]) && (csa_p[i] & csb_p[i])) begin
            cap[i] = '0; nb[i] = 0; viol[i] = 0; perbad[i] = 0; last_rise[i] = -1;
         end
         if (sclk_w[i] && !sclk_p[i]) begin
            if (!(csa_w[i] & csb_w[i])) begin
               cap[i] = {cap[i][22:0], sdio_w[i]};
               nb[i] = nb[i] + 1;
            end
            if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * div_v[i]) perbad[i] = perbad[i] + 1;
            last_rise[i] = cyc;
         end
         if (!sclk_w[i] && sclk_p[i] && last_rise[i] >= 0 && (cyc - last_rise[i]) != div_v[i])
            perbad[i] = perbad[i] + 1;
         if (sclk_w[i] && (sdio_w[i] != sdio_p[i])) viol[i] = viol[i] + 1;
         if (done_w[i]) begin dcnt[i] = dcnt[i] + 1; dn[i] = cyc; end
         sclk_p[i] = sclk_w[i];
         sdio_p[i] = sdio_w[i];
         csa_p[i]  = csa_w[i];
         csb_p[i]  = csb_w[i];
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write(input int i, input logic [1:0] sel, input logic [12:0] a, input logic [7:0] d);
      @(negedge clk);
      start[i] = 1'b1; adc_sel[i] = sel; addr[i] = a; wdata[i] = d;
      @(posedge clk); #1;
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int prev, input string tag);
      int k = 0;
      while (dcnt[i] == prev && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_done_cnt"}, dcnt[i] - prev, 1);
   endtask

   // Frame length: CS_SETUP + 48*CLK_DIV + CS_HOLD, done after CS_IDLE more cycles.
   task automatic frame_checks(input int i, input string tag, input logic [23:0] w, input int prev);
      int len;
      len = 2 + 48 * div_v[i] + 2;
      wait_done(i, prev, tag);
      check({tag, "_word"},        cap[i], w);
      check({tag, "_bits"},        nb[i], 24);
      check({tag, "_cs_low"},      ra[i] - fa[i], len);
      check({tag, "_done_at"},     dn[i] - fa[i], len + 4);
      check({tag, "_sclk_period"}, perbad[i], 0);
      check({tag, "_sdio_stable"}, viol[i], 0);
      check({tag, "_ready"},       ready_w[i], 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p, a0, b0, r1, k;
      logic [23:0] c1;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; adc_sel[i] = 2'b00; addr[i] = '0; wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {ready_w[0], done_w[0], sclk_w[0], sdio_w[0], csa_w[0], csb_w[0]}, 6'b100111);
      @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      repeat (2) @(posedge clk);

      // single write to ADC A
      p = dcnt[0]; b0 = blow[0];
      write(0, 2'b01, 13'h014, 8'hA5);
      check("t1_busy", ready_w[0], 0);
      frame_checks(0, "t1", 24'h0014A5, p);
      check("t1_csb_idle", blow[0] - b0, 0);

      // broadcast write
      p = dcnt[0];
      write(0, 2'b11, 13'h0FF, 8'h01);
      frame_checks(0, "t2", 24'h00FF01, p);
      check("t2_csb_fall", fb[0] - fa[0], 0);
      check("t2_csb_rise", rb[0] - ra[0], 0);

      // start during a frame is ignored
      p = dcnt[0]; b0 = blow[0];
      write(0, 2'b01, 13'h014, 8'hA5);
      repeat (48) @(posedge clk);
      @(negedge clk);
      start[0] = 1'b1; adc_sel[0] = 2'b10; addr[0] = 13'h1FFF; wdata[0] = 8'hFF;
      @(posedge clk); #1;
      start[0] = 1'b0;
      frame_checks(0, "t3", 24'h0014A5, p);
      check("t3_csb_idle", blow[0] - b0, 0);
      repeat (20) @(posedge clk);
      check("t3_one_done", dcnt[0] - p, 1);

      // start with no channel selected is ignored
      p = dcnt[0]; a0 = alow[0]; b0 = blow[0];
      @(negedge clk);
      start[0] = 1'b1; adc_sel[0] = 2'b00;
      @(posedge clk); #1;
      check("t4_ready", ready_w[0], 1);
      start[0] = 1'b0;
      repeat (20) @(posedge clk);
      check("t4_csa_idle", alow[0] - a0, 0);
      check("t4_csb_idle", blow[0] - b0, 0);
      check("t4_no_done", dcnt[0] - p, 0);

      // reset after the 10th rising sclk
      p = dcnt[0];
      write(0, 2'b01, 13'h014, 8'hA5);
      k = 0;
      do begin
         @(negedge clk); #1;
         k++;
      end while (nb[0] < 10 && k < 1000);
      check("t5_bits_before_rst", nb[0], 10);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      check("t5_rst_outs", {ready_w[0], done_w[0], sclk_w[0], sdio_w[0], csa_w[0], csb_w[0]}, 6'b100111);
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (300) @(posedge clk);
      check("t5_no_done", dcnt[0] - p, 0);
      p = dcnt[0];
      write(0, 2'b01, 13'h014, 8'hA5);
      frame_checks(0, "t5b", 24'h0014A5, p);

      // back-to-back with start held high
      p = dcnt[0];
      @(negedge clk);
      start[0] = 1'b1; adc_sel[0] = 2'b01; addr[0] = 13'h014; wdata[0] = 8'hA5;
      @(posedge clk); #1;
      addr[0] = 13'h0FF; wdata[0] = 8'h01;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!ready_w[0] && k < 1000);
      c1 = cap[0]; r1 = ra[0];
      @(posedge clk); #1;
      start[0] = 1'b0;
      check("t6_first_word", c1, 24'h0014A5);
      check("t6_first_done", dcnt[0] - p, 1);
      frame_checks(0, "t6b", 24'h00FF01, p + 1);
      check("t6_cs_gap", fa[0] - r1, 5);

      // CLK_DIV sweep
      p = dcnt[1];
      write(1, 2'b01, 13'h014, 8'hA5);
      frame_checks(1, "div1", 24'h0014A5, p);
      p = dcnt[2];
      write(2, 2'b01, 13'h1ABC, 8'h3C);
      frame_checks(2, "div7", 24'h1ABC3C, p);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
